// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM states, strobe constant and offset sign extension for the load/store unit
package lsu_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, DONE} state_e;
  // {ce_n, oe_n, we_n}
  localparam logic [2:0] STROBE_INACTIVE = 3'b111;
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction
endpackage

// File: rtl/lsu_addr_gen.sv
// lsu_addr_gen: effective word address and alignment flag from base + signed 16-bit offset
//   base_i/offset_i -> word_addr_o (eff[ADDR_W+1:2], wraps), misalign_o (eff[1:0] != 0)
module lsu_addr_gen
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 18
) (
  input  logic [31:0]       base_i,
  input  logic [15:0]       offset_i,
  output logic [ADDR_W-1:0] word_addr_o,
  output logic              misalign_o
);
  logic [31:0] eff;
  logic unused_hi;
  assign eff = base_i + sext16(offset_i);
  assign word_addr_o = eff[ADDR_W+1:2];
  assign misalign_o = |eff[1:0];
  assign unused_hi = ^eff[31:ADDR_W+2];
endmodule

// File: rtl/lsu_sram_ctrl.sv
// lsu_sram_ctrl: lw/sw sequencer driving an async SRAM with programmable wait states
//   req_*: one request accepted in IDLE; busy/req_ready stall the PC; done pulses on completion
//   rdata: last load result; err: misalignment pulse when MISALIGN_TRAP_EN is defined, else 0
//   sram_*: word address, write data/drive enable, read data, active-low ce/oe/we strobes
module lsu_sram_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [31:0]       req_base,
  input  logic [15:0]       req_offset,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);
  localparam int W  = WAIT_CYCLES < 1 ? 1 : WAIT_CYCLES;
  localparam int CW = W > 1 ? $clog2(W) : 1;
  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic              we_q, ce_n_q, oe_n_q, we_n_q, dq_oe_q, done_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [ADDR_W-1:0] word_addr;
  logic              misalign, trap;
  lsu_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .base_i     (req_base),
    .offset_i   (req_offset),
    .word_addr_o(word_addr),
    .misalign_o (misalign)
  );
`ifdef MISALIGN_TRAP_EN
  assign trap = misalign;
`else
  logic unused_misalign;
  assign unused_misalign = misalign;
  assign trap = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      {ce_n_q, oe_n_q, we_n_q} <= STROBE_INACTIVE;
      dq_oe_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          addr_q <= word_addr;
          we_q <= req_we;
          wdata_q <= req_wdata;
          // a trapped request skips the SRAM entirely and reports straight away
          state_q <= trap ? DONE : SETUP;
          done_q <= trap;
          err_q <= trap;
          ce_n_q <= trap;
          oe_n_q <= trap | req_we;
          dq_oe_q <= ~trap & req_we;
        end
        SETUP: begin
          state_q <= ACCESS;
          cnt_q <= CW'(W - 1);
          we_n_q <= ~we_q;
        end
        ACCESS: if (cnt_q == '0) begin
          state_q <= HOLD;
          we_n_q <= 1'b1;
          oe_n_q <= 1'b1;
          if (!we_q) rdata_q <= sram_dq_in;
        end else cnt_q <= cnt_q - CW'(1);
        HOLD: begin
          state_q <= DONE;
          {ce_n_q, oe_n_q, we_n_q} <= STROBE_INACTIVE;
          dq_oe_q <= 1'b0;
          done_q <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          done_q <= 1'b0;
          err_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign req_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign err = err_q;
  assign rdata = rdata_q;
  assign sram_addr = addr_q;
  assign sram_dq_out = wdata_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
endmodule
